bcd5_to_bin16: RTL

- Multi-cycle converter from a signed 5-digit BCD value (sign flag plus digits 0..4) to a 16-bit two's-complement word.
- Sits on the keypad/operand-entry path, feeding user-entered decimal operands to the CPU register file.
- It is the inverse of the display-side binary-to-BCD converter.
- Uses one shift-add multiply-by-10 accumulate per clock, with a start/busy/done handshake.

---
 rtl/bcd5_to_bin16_pkg.sv | 21 ++
 rtl/bcd_mac10.sv | 21 ++
 rtl/bcd5_to_bin16.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bcd5_to_bin16_pkg.sv
// ----------------------------------------------------------------------------
// bcd5_to_bin16_pkg
// Shared types and constants for the signed 5-digit BCD to 16-bit binary
// converter and its multiply-by-10 accumulate helper.
// ----------------------------------------------------------------------------
package bcd5_to_bin16_pkg;

    // Conversion FSM: capture operands, accumulate one digit per clock,
    // then range-check and publish the result.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int BIN_MAX_POS     = 32767;  // largest positive result
    localparam int BIN_MAX_NEG_MAG = 32768;  // largest negative magnitude
    localparam int BCD_DIGITS      = 5;
    localparam int ACC_W           = 17;     // holds 99999 without wrap

endpackage : bcd5_to_bin16_pkg

// File: rtl/bcd_mac10.sv
// ----------------------------------------------------------------------------
// bcd_mac10
// Combinational acc*10 + digit, built from two shifts and adds
// ((acc << 3) + (acc << 1) + digit). Result wraps modulo 2^ACC_W.
//
// Ports:
//   acc_in  [ACC_W-1:0]  running unsigned accumulator
//   digit   [3:0]        next BCD digit (not range-checked here)
//   acc_out [ACC_W-1:0]  acc_in*10 + digit
// ----------------------------------------------------------------------------
module bcd_mac10
    import bcd5_to_bin16_pkg::*;
(
    input  logic [ACC_W-1:0] acc_in,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] acc_out
);

    assign acc_out = (acc_in << 3) + (acc_in << 1) + ACC_W'(digit);

endmodule : bcd_mac10

// File: rtl/bcd5_to_bin16.sv
// ----------------------------------------------------------------------------
// bcd5_to_bin16
// Multi-cycle converter from a signed 5-digit BCD operand to a 16-bit
// two's-complement word. One multiply-by-10 accumulate per clock; fixed
// latency of 6 clocks from the start edge to the done pulse.
//
// Parameters:
//   SATURATE    1: clamp out-of-range results to 32767 / -32768; 0: force 0
//   NUM_DIGITS  number of BCD digits processed (5 in this revision)
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               conversion request, sampled only in IDLE
//   negative            sign of the operand (1 = negative)
//   bcd_digit0..4       units .. ten-thousands digits
//   bin                 result, held until the next done
//   busy                conversion in progress
//   done                one-cycle pulse: bin and flags updated
//   overflow            magnitude out of range for the sign (held)
//   invalid_digit       some digit was greater than 9 (held)
// ----------------------------------------------------------------------------
module bcd5_to_bin16
    import bcd5_to_bin16_pkg::*;
#(
    parameter bit SATURATE   = 1'b1,
    parameter int NUM_DIGITS = BCD_DIGITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        negative,
    input  logic [3:0]  bcd_digit0,
    input  logic [3:0]  bcd_digit1,
    input  logic [3:0]  bcd_digit2,
    input  logic [3:0]  bcd_digit3,
    input  logic [3:0]  bcd_digit4,
    output logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        invalid_digit
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [2:0]       cnt;
    logic             neg_q;
    logic             inv_q;
    logic [3:0]       digits [BCD_DIGITS];
    logic [3:0]       cur_digit;
    logic             any_invalid;

    assign any_invalid = (bcd_digit0 > 4'd9) | (bcd_digit1 > 4'd9) |
                         (bcd_digit2 > 4'd9) | (bcd_digit3 > 4'd9) |
                         (bcd_digit4 > 4'd9);

    // Digit feeding the MAC this cycle; cnt walks from the MSD down to 0.
    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        cur_digit = 4'd0;
        case (cnt)
            3'd0:    cur_digit = digits[0];
            3'd1:    cur_digit = digits[1];
            3'd2:    cur_digit = digits[2];
            3'd3:    cur_digit = digits[3];
            3'd4:    cur_digit = digits[4];
            default: cur_digit = 4'd0;
        endcase
    end

    bcd_mac10 u_mac (
        .acc_in  (acc),
        .digit   (cur_digit),
        .acc_out (acc_next)
    );

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            neg_q         <= 1'b0;
            inv_q         <= 1'b0;
            // NOTE: the five-entry digit store is tiny, so it is reset along
            // with the rest; larger memories would be left unreset.
            for (int i = 0; i < BCD_DIGITS; i++) begin
                digits[i] <= '0;
            end
            bin           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            invalid_digit <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Snapshot operands so inputs may change while busy.
                        neg_q     <= negative;
                        inv_q     <= any_invalid;
                        digits[0] <= bcd_digit0;
                        digits[1] <= bcd_digit1;
                        digits[2] <= bcd_digit2;
                        digits[3] <= bcd_digit3;
                        digits[4] <= bcd_digit4;
                        acc       <= '0;
                        cnt       <= 3'(NUM_DIGITS - 1);
                        busy      <= 1'b1;
                        state     <= ACCUM;
                    end
                end

                ACCUM: begin
                    acc <= acc_next;
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd0) begin
                        state <= FINISH;
                    end
                end

                FINISH: begin
                    if (inv_q) begin
                        bin           <= '0;
                        overflow      <= 1'b0;
                        invalid_digit <= 1'b1;
                    end else if (!neg_q && (acc > ACC_W'(BIN_MAX_POS))) begin
                        bin           <= SATURATE ? 16'(BIN_MAX_POS) : 16'd0;
                        overflow      <= 1'b1;
                        invalid_digit <= 1'b0;
                    end else if (neg_q && (acc > ACC_W'(BIN_MAX_NEG_MAG))) begin
                        bin           <= SATURATE ? 16'(BIN_MAX_NEG_MAG) : 16'd0;
                        overflow      <= 1'b1;
                        invalid_digit <= 1'b0;
                    end else begin
                        // Magnitude 32768 negates to 0x8000, which is exact.
                        bin           <= neg_q ? (16'd0 - acc[15:0]) : acc[15:0];
                        overflow      <= 1'b0;
                        invalid_digit <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : bcd5_to_bin16
